segment_arbiter: RTL

Round-robin bus arbiter for one AXI slave segment. It produces the one-hot `BUS_GRANTS` vector consumed by the segment address decoders (I/O and memory segments), holds a grant for the duration of one transaction, and recovers from decode errors and hung transactions. There is one instance per segment, between the master request lines and the segment decoder/mux.

---
 rtl/segment_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/segment_arbiter.sv
// segment_arbiter: round-robin grant generator for one AXI slave segment.
// Holds a one-hot grant per transaction, inserts a one-cycle turnaround
// after every grant, and terminates grants on decode error or watchdog expiry.
//
//   state   | meaning
//   IDLE    | no grant; arbitrate among pending requests
//   GRANT   | winner owns the segment until done / error / watchdog
//   RELEASE | one-cycle bus turnaround, error pulse reported here
//
// Outputs are registered from the current state, so they trail the FSM by
// one edge and never depend combinationally on any input.
module segment_arbiter #(
  parameter int masters = 2,
  parameter int timeout = 1024,
  localparam int IW = (masters > 1) ? $clog2(masters) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [masters-1:0] BUS_REQUESTS,
  input  logic               TXN_DONE,
  input  logic               SELECT_ERROR,
  output logic [masters-1:0] BUS_GRANTS,
  output logic [IW-1:0]      GRANT_ID,
  output logic               BUS_BUSY,
  output logic               DECODE_ERROR,
  output logic               TIMEOUT_ERROR
);

  // A disabled watchdog still gets a 1-bit counter so no zero-width vector exists.
  localparam int CW = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam int TC = (timeout > 0) ? timeout - 1 : 0;
  localparam logic [CW-1:0] TC_V = CW'(TC);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] win, cand;
  logic          found;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dec_q, dec_nxt;
  logic          to_q, to_nxt;
  logic          expire;
  logic [masters-1:0] one_hot;

  assign expire = (timeout != 0) && (cnt == TC_V);

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = '0;
    for (int i = 1; i <= masters; i++) begin
      cand = IW'((int'(last) + i) % masters);
      if (!found && BUS_REQUESTS[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state logic; exit priority in GRANT is done, then decode error, then watchdog.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    dec_nxt   = dec_q;
    to_nxt    = to_q;
    case (state)
      IDLE: begin
        dec_nxt = 1'b0;
        to_nxt  = 1'b0;
        if (found) begin
          state_nxt = GRANT;
          last_nxt  = win;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (cnt != '1) cnt_nxt = cnt + CW'(1);
        if (TXN_DONE) begin
          state_nxt = RELEASE;
        end else if (SELECT_ERROR) begin
          state_nxt = RELEASE;
          dec_nxt   = 1'b1;
        end else if (expire) begin
          state_nxt = RELEASE;
          to_nxt    = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, arbitration pointer, watchdog and pending-error flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last  <= IW'(masters - 1);
      cnt   <= '0;
      dec_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      dec_q <= dec_nxt;
      to_q  <= to_nxt;
    end
  end

  // One-hot decode of the current owner.
  always_comb begin
    one_hot       = '0;
    one_hot[last] = 1'b1;
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BUS_GRANTS    <= '0;
      GRANT_ID      <= '0;
      BUS_BUSY      <= 1'b0;
      DECODE_ERROR  <= 1'b0;
      TIMEOUT_ERROR <= 1'b0;
    end else begin
      BUS_GRANTS    <= (state == GRANT) ? one_hot : '0;
      GRANT_ID      <= (state == GRANT) ? last : '0;
      BUS_BUSY      <= (state == GRANT);
      DECODE_ERROR  <= (state == RELEASE) && dec_q;
      TIMEOUT_ERROR <= (state == RELEASE) && to_q;
    end
  end

endmodule
